csa_tree_pipe: RTL and testbench
================================

Name: csa_tree_pipe

Overview:
- Parametrised, pipelined carry-save reduction tree for the unsigned mantissa multiplier datapath.
- Accepts NUM_PP pre-aligned partial-product rows and reduces them with 3:2 compressor levels to a sum/carry pair.
- Pipeline registers sit between levels. A valid/ready handshake supports backpressure from the final adder stage.
- Replaces fixed-size, purely combinational trees so one block serves every multiplier width.

Parameters:
- OUT_W, 14: width of each input row and of both output rows; all arithmetic is modulo 2^OUT_W.
- NUM_PP, 4: number of partial-product rows; legal range 3..9.
- REG_STRIDE, 1: a pipeline register is placed after every REG_STRIDE compressor levels. The final level is always registered.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input rows valid.
- in_ready  output  1  block can accept input this cycle.
- in_pp  input  NUM_PP*OUT_W  packed rows, row k at bits [k*OUT_W +: OUT_W]; already shifted and zero-extended by the caller.
- out_valid  output  1  sum/carry valid.
- out_ready  input  1  downstream accepts output.
- out_sum  output  OUT_W  sum row.
- out_carry  output  OUT_W  carry row (bit 0 always 0).
- out_prod  output  OUT_W  present only with CSA_TREE_FINAL_ADD_EN.

Behaviour:
- Level count L: iterate r -> r - floor(r/3) from r=NUM_PP until r=2; L is the number of iterations (NUM_PP 3 gives L=1, 4 gives 2, 6 gives 3, 9 gives 4).
- Each level groups rows in threes, LSB-aligned. Each group feeds a 3:2 compressor per bit.
- Carry is shifted left one bit; carry out of bit OUT_W-1 is discarded.
- Leftover rows (r mod 3) pass through unchanged.
- Invariant: out_sum + out_carry == sum of all rows, mod 2^OUT_W.
- Stage count S = ceil(L/REG_STRIDE). Latency with no stall: S cycles from the in_valid&&in_ready edge to out_valid.
- Each stage k holds a valid bit v[k] and data registers.
- ready[k] = !v[k] || ready[k+1]; ready[S] = out_ready; in_ready = ready[0].
- Stage data loads only when its upstream valid and ready[k] are both high. Data registers do not toggle otherwise.
- Bubbles collapse: a stage with v=0 accepts even when downstream is stalled.
- Full: with out_ready=0 the pipeline holds exactly S transactions, and in_ready then deasserts in the same cycle.
- Simultaneous accept and emit on a full pipeline sustains one transaction per cycle with no bubble.
- Outputs are stable while out_valid=1 and out_ready=0.
- in_pp is ignored when in_valid=0.
- Reset (asynchronous, any time including mid-flight): all v[k]=0, out_valid=0, in_ready=1 on the cycle after deassertion. out_sum, out_carry and out_prod reset to 0. In-flight transactions are dropped.
- in_ready during reset is 0.

Optional Feature:
- CSA_TREE_FINAL_ADD_EN defined:
  - Adds one extra registered stage (S+1 total) holding out_prod = out_sum + out_carry mod 2^OUT_W.
  - That stage is part of the same ready chain; out_sum and out_carry are delayed to stay aligned with out_prod.
  - Latency is S+1 and capacity is S+1.
- CSA_TREE_FINAL_ADD_EN undefined:
  - The out_prod port does not exist; latency is S.

Test Plan:
- OUT_W=14, NUM_PP=4, REG_STRIDE=1, rows 3,5,7,9 with out_ready=1 -> out_valid exactly 2 cycles after accept; out_sum+out_carry mod 2^14 = 24.
- Four rows of 0x3FFF -> out_sum+out_carry mod 2^14 = 0x3FFC; carry out of the MSB is dropped.
- out_ready=0 and 5 back-to-back inputs -> exactly 2 accepted, in_ready=0 afterwards, outputs frozen. Release out_ready -> all values emerge in order with none lost or duplicated.
- Randomised in_valid/out_ready over 1000 transactions at NUM_PP=3, 6 and 9 with REG_STRIDE 1 and 2 -> scoreboard matches the modulo sum; latency equals S when there are no stalls.
- Assert rst_n mid-flight with 2 transactions held -> out_valid=0 immediately; after release in_ready=1, no stale output appears, and the first new result is correct.
- With CSA_TREE_FINAL_ADD_EN, rows 3,5,7,9 -> out_prod=24 on cycle 3 after accept; backpressure capacity is 3.

Source files
------------

// File: rtl/csa_tree_pipe.sv
// csa_tree_pipe
//
// Pipelined carry-save reduction tree for the unsigned mantissa multiplier.
// NUM_PP pre-aligned partial-product rows are reduced level by level with
// 3:2 compressors until a single sum/carry pair remains. A pipeline register
// follows every REG_STRIDE levels, and the last level is always registered.
// The stages are linked by a valid/ready chain, so the final adder can apply
// backpressure.
//
// Optional build macro: CSA_TREE_FINAL_ADD_EN
//   When it is defined, one extra registered stage is appended. That stage
//   holds out_prod = out_sum + out_carry and keeps sum/carry aligned with it.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in_valid   input rows valid
//   in_ready   block can accept input this cycle (0 while in reset)
//   in_pp      NUM_PP packed rows, row k at [k*OUT_W +: OUT_W]
//   out_valid  sum/carry valid
//   out_ready  downstream accepts output
//   out_sum    sum row
//   out_carry  carry row (bit 0 always 0)
//   out_prod   out_sum + out_carry (only with CSA_TREE_FINAL_ADD_EN)
module csa_tree_pipe #(
   parameter int OUT_W      = 14,
   parameter int NUM_PP     = 4,
   parameter int REG_STRIDE = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_PP*OUT_W-1:0] in_pp,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUT_W-1:0]        out_sum,
   output logic [OUT_W-1:0]        out_carry
`ifdef CSA_TREE_FINAL_ADD_EN
   ,
   output logic [OUT_W-1:0]        out_prod
`endif
);

   // Returns the row count left after the given number of levels.
   function automatic int rowsAfter(input int levels);
      int r;
      r = NUM_PP;
      for (int i = 0; i < levels; i++) r = r - r / 3;
      return r;
   endfunction

   // Returns the number of levels needed to reach two rows.
   function automatic int countLevels(input int rows);
      int r;
      int n;
      r = rows;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         if (r > 2) begin
            r = r - r / 3;
            n = n + 1;
         end
      end
      return n;
   endfunction

   localparam int L = countLevels(NUM_PP);
   localparam int S = (L + REG_STRIDE - 1) / REG_STRIDE;
`ifdef CSA_TREE_FINAL_ADD_EN
   localparam int NS = S + 1;
`else
   localparam int NS = S;
`endif

   logic [NS-1:0]      valid_q;
   logic [NS-1:0]      valid_d;
   logic [NS-1:0]      upValid;
   logic [NS-1:0]      loadEn;
   logic [NS:0]        ready;
   logic [2*OUT_W-1:0] finalRows;

   // The ready chain runs from the output back to the input. A stage is ready
   // when it is empty or when its contents can move on, so bubbles collapse.
   always_comb begin
      ready      = '0;
      upValid    = '0;
      ready[NS]  = out_ready;
      for (int k = NS - 1; k >= 0; k--) begin
         ready[k] = ~valid_q[k] | ready[k+1];
      end
      upValid[0] = in_valid;
      for (int k = 1; k < NS; k++) begin
         upValid[k] = valid_q[k-1];
      end
      loadEn  = upValid & ready[NS-1:0];
      valid_d = (upValid & ready[NS-1:0]) | (valid_q & ~ready[NS-1:0]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= '0;
      else        valid_q <= valid_d;
   end

   // While reset is held the empty pipeline would look ready, so it is masked.
   assign in_ready  = rst_n & ready[0];
   assign out_valid = valid_q[NS-1];

   // One generate block per compressor level. Rows are grouped in threes from
   // row 0, and the leftover rows move down unchanged behind the new pairs.
   for (genvar l = 0; l < L; l++) begin : g_lvl
      localparam int RIN  = rowsAfter(l);
      localparam int ROUT = rowsAfter(l + 1);
      localparam int NGRP = RIN / 3;
      localparam int STG  = l / REG_STRIDE;
      localparam bit REG  = ((l + 1) % REG_STRIDE == 0) || (l == L - 1);

      logic [RIN*OUT_W-1:0]  rowsIn;
      logic [ROUT*OUT_W-1:0] rowsComb;
      logic [ROUT*OUT_W-1:0] rowsOut;

      if (l == 0) begin : g_src
         assign rowsIn = in_pp;
      end else begin : g_src
         assign rowsIn = g_lvl[l-1].rowsOut;
      end

      // The carry is shifted left one bit, and the carry out of the MSB is
      // dropped because the arithmetic is modulo 2^OUT_W.
      always_comb begin : p_compress
         logic [OUT_W-1:0] a;
         logic [OUT_W-1:0] b;
         logic [OUT_W-1:0] c;
         a        = '0;
         b        = '0;
         c        = '0;
         rowsComb = '0;
         for (int g = 0; g < NGRP; g++) begin
            a = rowsIn[(3*g)*OUT_W   +: OUT_W];
            b = rowsIn[(3*g+1)*OUT_W +: OUT_W];
            c = rowsIn[(3*g+2)*OUT_W +: OUT_W];
            rowsComb[(2*g)*OUT_W   +: OUT_W] = a ^ b ^ c;
            rowsComb[(2*g+1)*OUT_W +: OUT_W] = ((a & b) | (a & c) | (b & c)) << 1;
         end
         for (int j = 0; j < RIN % 3; j++) begin
            rowsComb[(2*NGRP+j)*OUT_W +: OUT_W] = rowsIn[(3*NGRP+j)*OUT_W +: OUT_W];
         end
      end

      if (REG) begin : g_reg
         logic [ROUT*OUT_W-1:0] rows_q;
         // The stage register only captures data on an actual transfer, so
         // held data never toggles during a stall.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)              rows_q <= '0;
            else if (loadEn[STG])    rows_q <= rowsComb;
         end
         assign rowsOut = rows_q;
      end else begin : g_comb
         assign rowsOut = rowsComb;
      end

      if (l == L - 1) begin : g_last
         assign finalRows = rowsOut;
      end
   end

`ifdef CSA_TREE_FINAL_ADD_EN
   logic [OUT_W-1:0] sum_q;
   logic [OUT_W-1:0] carry_q;
   logic [OUT_W-1:0] prod_q;

   // The final adder stage registers sum and carry with the product, so all
   // three outputs always describe the same transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q   <= '0;
         carry_q <= '0;
         prod_q  <= '0;
      end else if (loadEn[NS-1]) begin
         sum_q   <= finalRows[OUT_W-1:0];
         carry_q <= finalRows[2*OUT_W-1:OUT_W];
         prod_q  <= finalRows[OUT_W-1:0] + finalRows[2*OUT_W-1:OUT_W];
      end
   end

   assign out_sum   = sum_q;
   assign out_carry = carry_q;
   assign out_prod  = prod_q;
`else
   assign out_sum   = finalRows[OUT_W-1:0];
   assign out_carry = finalRows[2*OUT_W-1:OUT_W];
`endif

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Testbench for csa_tree_pipe. Instance 0 uses the default configuration.
// The other instances cover NUM_PP 3, 6 and 9 with REG_STRIDE 1 and 2.
module tb_csa_tree_pipe;

   localparam int W     = 14;
   localparam int NI    = 6;
   localparam int MAXPP = 9;
`ifdef CSA_TREE_FINAL_ADD_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   function automatic int nppOf(input int i);
      case (i)
         0:       return 4;
         1:       return 3;
         2:       return 6;
         3:       return 6;
         default: return 9;
      endcase
   endfunction

   function automatic int rsOf(input int i);
      case (i)
         3, 5:    return 2;
         default: return 1;
      endcase
   endfunction

   // Expected latency per instance:
   //   NUM_PP 4 -> 2 levels; 3 -> 1; 6 -> 3; 9 -> 4.
   //   Stage count is ceil(levels / stride). Add one for the final adder.
   function automatic int latOf(input int i);
      case (i)
         0:       return 2 + EXTRA;
         1:       return 1 + EXTRA;
         2:       return 3 + EXTRA;
         3:       return 2 + EXTRA;
         4:       return 4 + EXTRA;
         default: return 2 + EXTRA;
      endcase
   endfunction

   localparam int LAT0 = 2 + EXTRA;

   logic                          clk = 1'b0;
   logic                          rst_n;
   logic [NI-1:0]                 inValid;
   logic [NI-1:0]                 inReady;
   logic [NI-1:0]                 outValid;
   logic [NI-1:0]                 outReady;
   logic [NI-1:0][MAXPP*W-1:0]    inPp;
   logic [NI-1:0][W-1:0]          outSum;
   logic [NI-1:0][W-1:0]          outCarry;
`ifdef CSA_TREE_FINAL_ADD_EN
   logic [NI-1:0][W-1:0]          outProd;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar i = 0; i < NI; i++) begin : g_dut
      localparam int NPP = nppOf(i);
      localparam int RS  = rsOf(i);
      csa_tree_pipe #(.OUT_W(W), .NUM_PP(NPP), .REG_STRIDE(RS)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (inValid[i]),
         .in_ready  (inReady[i]),
         .in_pp     (inPp[i][NPP*W-1:0]),
         .out_valid (outValid[i]),
         .out_ready (outReady[i]),
         .out_sum   (outSum[i]),
`ifdef CSA_TREE_FINAL_ADD_EN
         .out_prod  (outProd[i]),
`endif
         .out_carry (outCarry[i])
      );
   end

   // Watchdog so that the run always terminates.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion earlier");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic setIdle();
      inValid  = '0;
      outReady = '1;
      inPp     = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      setIdle();
      repeat (2) @(negedge clk);
      #1;
      checks++; if (inReady[0] !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", inReady[0]); end
      checks++; if (outValid[0] !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", outValid[0]); end
      checks++; if (outSum[0] !== '0) begin errors++; $display("[TB] FAIL reset_out_sum: got %h expected 0", outSum[0]); end
      checks++; if (outCarry[0] !== '0) begin errors++; $display("[TB] FAIL reset_out_carry: got %h expected 0", outCarry[0]); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checks++; if (inReady[0] !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1", inReady[0]); end
      checks++; if (outValid[0] !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_out_valid: got %b expected 0", outValid[0]); end
   endtask

   task automatic test_basic();
      int n;
      logic [W-1:0] tot;
      @(negedge clk);
      outReady[0] = 1'b1;
      inValid[0]  = 1'b1;
      inPp[0]     = '0;
      inPp[0][4*W-1:0] = {14'd9, 14'd7, 14'd5, 14'd3};
      #1;
      checks++; if (inReady[0] !== 1'b1) begin errors++; $display("[TB] FAIL basic_accept: got %b expected 1", inReady[0]); end
      @(negedge clk);
      inValid[0] = 1'b0;
      inPp[0]    = '1;
      n = 1;
      #1;
      while (!outValid[0] && n < LAT0 + 4) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++; if (n != LAT0) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected %0d", n, LAT0); end
      tot = outSum[0] + outCarry[0];
      checks++; if (tot !== 14'd24) begin errors++; $display("[TB] FAIL basic_sum: got %0d expected 24", tot); end
`ifdef CSA_TREE_FINAL_ADD_EN
      checks++; if (outProd[0] !== 14'd24) begin errors++; $display("[TB] FAIL basic_prod: got %0d expected 24", outProd[0]); end
`endif
      @(negedge clk);
      #1;
      checks++; if (outValid[0] !== 1'b0) begin errors++; $display("[TB] FAIL basic_single_output: got %b expected 0", outValid[0]); end
   endtask

   task automatic test_saturate();
      int n;
      logic [W-1:0] tot;
      @(negedge clk);
      inValid[0] = 1'b1;
      inPp[0]    = '0;
      inPp[0][4*W-1:0] = {4{14'h3FFF}};
      #1;
      @(negedge clk);
      inValid[0] = 1'b0;
      n = 1;
      #1;
      while (!outValid[0] && n < LAT0 + 4) begin
         @(negedge clk);
         #1;
         n++;
      end
      tot = outSum[0] + outCarry[0];
      checks++; if (tot !== 14'h3FFC) begin errors++; $display("[TB] FAIL saturate_sum: got %h expected 3ffc", tot); end
      checks++; if (outCarry[0][0] !== 1'b0) begin errors++; $display("[TB] FAIL saturate_carry_lsb: got %b expected 0", outCarry[0][0]); end
`ifdef CSA_TREE_FINAL_ADD_EN
      checks++; if (outProd[0] !== 14'h3FFC) begin errors++; $display("[TB] FAIL saturate_prod: got %h expected 3ffc", outProd[0]); end
`endif
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [4*W-1:0] vecs [5];
      logic [W-1:0]   expv [5];
      logic [W-1:0]   heldSum;
      logic [W-1:0]   heldCarry;
      logic [W-1:0]   tot;
      int sent;
      int got;
      int frozenBad;
      int extra;
      for (int k = 0; k < 5; k++) begin
         vecs[k] = {14'($urandom), 14'($urandom), 14'($urandom), 14'($urandom)};
         expv[k] = vecs[k][0 +: W] + vecs[k][W +: W] + vecs[k][2*W +: W] + vecs[k][3*W +: W];
      end
      sent = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         outReady[0] = 1'b0;
         inValid[0]  = 1'b1;
         inPp[0]     = '0;
         inPp[0][4*W-1:0] = vecs[sent];
         #1;
         if (inReady[0]) sent++;
      end
      @(negedge clk);
      inValid[0] = 1'b0;
      #1;
      checks++; if (sent != LAT0) begin errors++; $display("[TB] FAIL bp_capacity: got %0d expected %0d", sent, LAT0); end
      checks++; if (inReady[0] !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready: got %b expected 0", inReady[0]); end
      heldSum   = outSum[0];
      heldCarry = outCarry[0];
      frozenBad = 0;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (outValid[0] !== 1'b1 || outSum[0] !== heldSum || outCarry[0] !== heldCarry) frozenBad++;
      end
      checks++; if (frozenBad != 0) begin errors++; $display("[TB] FAIL bp_frozen: got %0d changed cycles expected 0", frozenBad); end
      got = 0;
      for (int c = 0; c < 40 && got < 5; c++) begin
         @(negedge clk);
         outReady[0] = 1'b1;
         inValid[0]  = (sent < 5);
         if (sent < 5) inPp[0][4*W-1:0] = vecs[sent];
         #1;
         if (outValid[0]) begin
            tot = outSum[0] + outCarry[0];
            checks++; if (tot !== expv[got]) begin errors++; $display("[TB] FAIL bp_order_%0d: got %h expected %h", got, tot, expv[got]); end
            got++;
         end
         if (inValid[0] && inReady[0]) sent++;
      end
      checks++; if (got != 5) begin errors++; $display("[TB] FAIL bp_drain_count: got %0d expected 5", got); end
      @(negedge clk);
      inValid[0] = 1'b0;
      extra = 0;
      repeat (LAT0 + 2) begin
         @(negedge clk);
         #1;
         if (outValid[0]) extra++;
      end
      checks++; if (extra != 0) begin errors++; $display("[TB] FAIL bp_duplicates: got %0d extra outputs expected 0", extra); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] expQ [$];
      logic [W-1:0] e;
      logic [W-1:0] tot;
      int guard;
      guard = 0;
      @(negedge clk);
      outReady[0] = 1'b0;
      inValid[0]  = 1'b1;
      while (guard < 10) begin
         for (int r = 0; r < 4; r++) inPp[0][r*W +: W] = 14'($urandom);
         #1;
         if (!inReady[0]) break;
         expQ.push_back(inPp[0][0 +: W] + inPp[0][W +: W] + inPp[0][2*W +: W] + inPp[0][3*W +: W]);
         @(negedge clk);
         guard++;
      end
      for (int c = 0; c < 8; c++) begin
         if (c > 0) @(negedge clk);
         outReady[0] = 1'b1;
         inValid[0]  = 1'b1;
         for (int r = 0; r < 4; r++) inPp[0][r*W +: W] = 14'($urandom);
         #1;
         checks++; if (inReady[0] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready_%0d: got %b expected 1", c, inReady[0]); end
         checks++; if (outValid[0] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_out_valid_%0d: got %b expected 1", c, outValid[0]); end
         if (outValid[0] && expQ.size() > 0) begin
            e   = expQ.pop_front();
            tot = outSum[0] + outCarry[0];
            checks++; if (tot !== e) begin errors++; $display("[TB] FAIL b2b_value_%0d: got %h expected %h", c, tot, e); end
         end
         if (inReady[0]) expQ.push_back(inPp[0][0 +: W] + inPp[0][W +: W] + inPp[0][2*W +: W] + inPp[0][3*W +: W]);
      end
      guard = 0;
      while (expQ.size() > 0 && guard < 20) begin
         @(negedge clk);
         inValid[0] = 1'b0;
         #1;
         if (outValid[0]) begin
            e   = expQ.pop_front();
            tot = outSum[0] + outCarry[0];
            checks++; if (tot !== e) begin errors++; $display("[TB] FAIL b2b_drain: got %h expected %h", tot, e); end
         end
         guard++;
      end
      checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL b2b_drain_count: got %0d left expected 0", expQ.size()); end
   endtask

   task automatic test_reset_midflight();
      int stale;
      int n;
      logic [W-1:0] e;
      logic [W-1:0] tot;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         outReady[0] = 1'b0;
         inValid[0]  = 1'b1;
         for (int r = 0; r < 4; r++) inPp[0][r*W +: W] = 14'($urandom);
         #1;
      end
      @(negedge clk);
      inValid[0] = 1'b0;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (outValid[0] !== 1'b0) begin errors++; $display("[TB] FAIL midreset_out_valid: got %b expected 0", outValid[0]); end
      checks++; if (inReady[0] !== 1'b0) begin errors++; $display("[TB] FAIL midreset_in_ready: got %b expected 0", inReady[0]); end
      @(negedge clk);
      rst_n       = 1'b1;
      outReady[0] = 1'b1;
      @(negedge clk);
      #1;
      checks++; if (inReady[0] !== 1'b1) begin errors++; $display("[TB] FAIL midreset_release_ready: got %b expected 1", inReady[0]); end
      stale = 0;
      repeat (LAT0 + 2) begin
         @(negedge clk);
         #1;
         if (outValid[0]) stale++;
      end
      checks++; if (stale != 0) begin errors++; $display("[TB] FAIL midreset_stale: got %0d outputs expected 0", stale); end
      @(negedge clk);
      inValid[0] = 1'b1;
      for (int r = 0; r < 4; r++) inPp[0][r*W +: W] = 14'($urandom);
      e = inPp[0][0 +: W] + inPp[0][W +: W] + inPp[0][2*W +: W] + inPp[0][3*W +: W];
      @(negedge clk);
      inValid[0] = 1'b0;
      n = 1;
      #1;
      while (!outValid[0] && n < LAT0 + 4) begin
         @(negedge clk);
         #1;
         n++;
      end
      tot = outSum[0] + outCarry[0];
      checks++; if (n != LAT0) begin errors++; $display("[TB] FAIL midreset_new_latency: got %0d expected %0d", n, LAT0); end
      checks++; if (tot !== e) begin errors++; $display("[TB] FAIL midreset_new_value: got %h expected %h", tot, e); end
      @(negedge clk);
   endtask

   task automatic test_random(input int idx, input int npp, input int lat, input int n);
      logic [W-1:0] expQ [$];
      int           cycQ [$];
      logic [W-1:0] e;
      logic [W-1:0] tot;
      logic [W-1:0] heldSum;
      logic [W-1:0] heldCarry;
      logic         stallPrev;
      int           c0;
      int           sent;
      int           cyc;
      for (int ph = 0; ph < 2; ph++) begin
         sent      = 0;
         cyc       = 0;
         stallPrev = 1'b0;
         heldSum   = '0;
         heldCarry = '0;
         while ((sent < n || expQ.size() > 0) && cyc < 8000) begin
            @(negedge clk);
            inValid[idx]  = (sent < n) && ($urandom_range(3) != 0);
            outReady[idx] = (ph == 0) ? 1'b1 : ($urandom_range(1) == 1);
            for (int r = 0; r < MAXPP; r++) inPp[idx][r*W +: W] = 14'($urandom);
            #1;
            if (stallPrev) begin
               checks++;
               if (outValid[idx] !== 1'b1 || outSum[idx] !== heldSum || outCarry[idx] !== heldCarry) begin
                  errors++;
                  $display("[TB] FAIL rnd%0d_hold: got v=%b %h/%h expected v=1 %h/%h", idx, outValid[idx], outSum[idx], outCarry[idx], heldSum, heldCarry);
               end
            end
            if (outValid[idx] && outReady[idx]) begin
               checks++;
               if (expQ.size() == 0) begin
                  errors++;
                  $display("[TB] FAIL rnd%0d_spurious: got an output expected none pending", idx);
               end else begin
                  e   = expQ.pop_front();
                  c0  = cycQ.pop_front();
                  tot = outSum[idx] + outCarry[idx];
                  if (tot !== e) begin errors++; $display("[TB] FAIL rnd%0d_value: got %h expected %h", idx, tot, e); end
                  checks++; if (outCarry[idx][0] !== 1'b0) begin errors++; $display("[TB] FAIL rnd%0d_carry_lsb: got 1 expected 0", idx); end
`ifdef CSA_TREE_FINAL_ADD_EN
                  checks++; if (outProd[idx] !== e) begin errors++; $display("[TB] FAIL rnd%0d_prod: got %h expected %h", idx, outProd[idx], e); end
`endif
                  if (ph == 0) begin
                     checks++; if (cyc - c0 != lat) begin errors++; $display("[TB] FAIL rnd%0d_latency: got %0d expected %0d", idx, cyc - c0, lat); end
                  end
               end
            end
            stallPrev = outValid[idx] && !outReady[idx];
            heldSum   = outSum[idx];
            heldCarry = outCarry[idx];
            if (inValid[idx] && inReady[idx]) begin
               e = '0;
               for (int r = 0; r < npp; r++) e = e + inPp[idx][r*W +: W];
               expQ.push_back(e);
               cycQ.push_back(cyc);
               sent++;
            end
            cyc++;
         end
         checks++;
         if (sent != n || expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL rnd%0d_complete: got sent=%0d pending=%0d expected sent=%0d pending=0", idx, sent, expQ.size(), n);
         end
      end
      @(negedge clk);
      inValid[idx]  = 1'b0;
      outReady[idx] = 1'b1;
   endtask

   initial begin
      $display("[TB] starting csa_tree_pipe bench");
      test_reset();
      test_basic();
      test_saturate();
      test_backpressure();
      test_back_to_back();
      test_reset_midflight();
      for (int i = 0; i < NI; i++) begin
         test_random(i, nppOf(i), latOf(i), 500);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
